// File: rtl/counter_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the counter command
// controller. STEP support is selected with the CTR_STEP_CMD_EN macro.
package counter_ctrl_pkg;

    localparam int OP_W = 8;

    localparam logic [OP_W-1:0] OP_NOP     = 8'h00;
    localparam logic [OP_W-1:0] OP_LOAD    = 8'h01;
    localparam logic [OP_W-1:0] OP_RUN     = 8'h02;
    localparam logic [OP_W-1:0] OP_STOP    = 8'h03;
    localparam logic [OP_W-1:0] OP_OE_ON   = 8'h04;
    localparam logic [OP_W-1:0] OP_OE_OFF  = 8'h05;
    localparam logic [OP_W-1:0] OP_STEP    = 8'h06;
    localparam logic [OP_W-1:0] OP_CLR_ERR = 8'h07;

`ifdef CTR_STEP_CMD_EN
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GET_ARG,
        ST_LOAD_PULSE,
        ST_STEP_RUN
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GET_ARG,
        ST_LOAD_PULSE
    } state_t;
`endif

    // Opcodes that are followed by one argument byte
    function automatic logic needs_arg(input logic [OP_W-1:0] op);
`ifdef CTR_STEP_CMD_EN
        return (op == OP_LOAD) || (op == OP_STEP);
`else
        return (op == OP_LOAD);
`endif
    endfunction

endpackage

// File: rtl/counter_cmd_ctrl_step_burst.sv
// Loadable down-counter that times a STEP burst; o_done flags the last
// cycle of the burst so the controller can leave STEP_RUN on that edge.
module step_burst #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [STEP_W-1:0] i_val,
    input  logic              i_dec,
    output logic              o_done
);

    logic [STEP_W-1:0] r_cnt;

    // Load with the burst length, then count down once per burst cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt <= STEP_W'(1));

endmodule

// File: rtl/counter_cmd_ctrl.sv
// Byte command decoder driving the programmable counter control inputs.
// Optional STEP burst command compiled in with CTR_STEP_CMD_EN.
module counter_cmd_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int STEP_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       ctr_en,
    output logic       ctr_load,
    output logic [7:0] ctr_load_val,
    output logic       ctr_oe,
    output logic       busy,
    output logic       err
);

    if (STEP_W < 1) begin : g_bad_step_w
        $error("STEP_W must be at least 1");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_run;
    logic       w_run_nxt;
    logic       r_oe;
    logic       w_oe_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic [7:0] r_load_val;
    logic [7:0] w_load_val_nxt;
    logic       r_ctr_en;
    logic       r_ctr_load;
    logic       w_en_nxt;
    logic       w_xfer;

    assign cmd_ready = !rst && ((r_state == ST_IDLE) ||
                                (r_state == ST_GET_ARG));
    assign busy      = !rst && (r_state != ST_IDLE);
    assign w_xfer    = cmd_valid && cmd_ready;

`ifdef CTR_STEP_CMD_EN
    logic              r_pend_step;
    logic              w_pend_step_nxt;
    logic              w_step_load;
    logic              w_step_dec;
    logic              w_step_done;
    logic [STEP_W-1:0] w_step_arg;

    assign w_step_arg = STEP_W'(cmd_data);

    step_burst #(
        .STEP_W (STEP_W)
    ) u_step_burst (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_step_load),
        .i_val  (w_step_arg),
        .i_dec  (w_step_dec),
        .o_done (w_step_done)
    );

    // Remember which argument-taking opcode is waiting for its byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_step <= 1'b0;
        end else begin
            r_pend_step <= w_pend_step_nxt;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-flag decode of the accepted byte
    always_comb begin
        w_state_nxt    = r_state;
        w_run_nxt      = r_run;
        w_oe_nxt       = r_oe;
        w_err_nxt      = r_err;
        w_load_val_nxt = r_load_val;
`ifdef CTR_STEP_CMD_EN
        w_pend_step_nxt = r_pend_step;
        w_step_load     = 1'b0;
        w_step_dec      = 1'b0;
`endif
        unique case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (needs_arg(cmd_data)) begin
                        w_state_nxt = ST_GET_ARG;
`ifdef CTR_STEP_CMD_EN
                        w_pend_step_nxt = (cmd_data == OP_STEP);
`endif
                    end else begin
                        case (cmd_data)
                            OP_NOP:     ;
                            OP_RUN:     w_run_nxt = 1'b1;
                            OP_STOP:    w_run_nxt = 1'b0;
                            OP_OE_ON:   w_oe_nxt  = 1'b1;
                            OP_OE_OFF:  w_oe_nxt  = 1'b0;
                            OP_CLR_ERR: w_err_nxt = 1'b0;
                            default:    w_err_nxt = 1'b1;
                        endcase
                    end
                end
            end
            ST_GET_ARG: begin
                if (w_xfer) begin
`ifdef CTR_STEP_CMD_EN
                    if (r_pend_step) begin
                        if (w_step_arg != '0) begin
                            w_state_nxt = ST_STEP_RUN;
                            w_step_load = 1'b1;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_load_val_nxt = cmd_data;
                        w_state_nxt    = ST_LOAD_PULSE;
                    end
`else
                    w_load_val_nxt = cmd_data;
                    w_state_nxt    = ST_LOAD_PULSE;
`endif
                end
            end
            ST_LOAD_PULSE: begin
                w_state_nxt = ST_IDLE;
            end
`ifdef CTR_STEP_CMD_EN
            ST_STEP_RUN: begin
                w_step_dec = 1'b1;
                if (w_step_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
`ifdef CTR_STEP_CMD_EN
        w_en_nxt = (w_state_nxt == ST_STEP_RUN) || w_run_nxt;
`else
        w_en_nxt = w_run_nxt;
`endif
    end

    // Registered flags and counter control outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run      <= 1'b0;
            r_oe       <= 1'b0;
            r_err      <= 1'b0;
            r_load_val <= 8'h00;
            r_ctr_en   <= 1'b0;
            r_ctr_load <= 1'b0;
        end else begin
            r_run      <= w_run_nxt;
            r_oe       <= w_oe_nxt;
            r_err      <= w_err_nxt;
            r_load_val <= w_load_val_nxt;
            r_ctr_en   <= w_en_nxt;
            r_ctr_load <= (w_state_nxt == ST_LOAD_PULSE);
        end
    end

    assign ctr_en       = r_ctr_en;
    assign ctr_load     = r_ctr_load;
    assign ctr_load_val = r_load_val;
    assign ctr_oe       = r_oe;
    assign err          = r_err;

endmodule

// File: tb/tb_counter_cmd_ctrl.sv
// Self-checking bench for counter_cmd_ctrl with a per-cycle expected-output
// queue; STEP scenarios are built when CTR_STEP_CMD_EN is defined.
module tb_counter_cmd_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       ctr_en;
    logic       ctr_load;
    logic [7:0] ctr_load_val;
    logic       ctr_oe;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic       m_run;
    logic       m_oe;
    logic       m_err;
    logic [7:0] m_lv;
    logic [13:0] q[$];

    counter_cmd_ctrl #(
        .STEP_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .ctr_en       (ctr_en),
        .ctr_load     (ctr_load),
        .ctr_load_val (ctr_load_val),
        .ctr_oe       (ctr_oe),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // {en, load, load_val, oe, busy, ready, err}
    function automatic logic [13:0] mk(input logic en, input logic ld,
                                       input logic bz, input logic rdy);
        return {en, ld, m_lv, m_oe, bz, rdy, m_err};
    endfunction

    function automatic logic [13:0] obs();
        return {ctr_en, ctr_load, ctr_load_val, ctr_oe, busy, cmd_ready, err};
    endfunction

    // Reference decode of a single-byte opcode
    task automatic apply_op(input logic [7:0] b);
        case (b)
            8'h00: ;
            8'h02: m_run = 1'b1;
            8'h03: m_run = 1'b0;
            8'h04: m_oe  = 1'b1;
            8'h05: m_oe  = 1'b0;
            8'h07: m_err = 1'b0;
            default: m_err = 1'b1;
        endcase
    endtask

    // Present one byte and hold it until the DUT takes it
    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        cmd_data  = b;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (w >= 300) begin
            errors++;
            $display("FAIL send_timeout byte %h ready %b required 1", b, cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [13:0] e;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        rst       = 1'b1;
        m_run = 0; m_oe = 0; m_err = 0; m_lv = 8'h00;
        repeat (2) q.push_back(mk(0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset[%0d] got %h exp %h", i, obs(), e);
            end
        end
        rst = 1'b0;
        repeat (5) q.push_back(mk(0, 0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL idle[%0d] got %h exp %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_load();
        logic [13:0] e;
        send_byte(8'h01);
        q.push_back(mk(m_run, 0, 1, 1));
        send_byte(8'hA5);
        m_lv = 8'hA5;
        q.push_back(mk(m_run, 1, 1, 0));
        repeat (2) q.push_back(mk(m_run, 0, 0, 1));
        // first entry is the GET_ARG cycle sampled before the argument
        e = q.pop_front();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL load[%0d] got %h exp %h", i, obs(), e);
            end
        end
    endtask

    task automatic test_run_oe();
        logic [13:0] e;
        logic [7:0]  ops[5];
        ops = '{8'h02, 8'h04, 8'h00, 8'h03, 8'h05};
        for (int i = 0; i < 5; i++) begin
            send_byte(ops[i]);
            apply_op(ops[i]);
            q.push_back(mk(m_run, 0, 0, 1));
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL run_oe op %h got %h exp %h", ops[i], obs(), e);
            end
        end
    endtask

    task automatic test_err();
        logic [13:0] e;
        logic [7:0]  ops[$];
        ops = '{8'h3C, 8'h00, 8'h02, 8'h07, 8'h03, 8'hFF, 8'h08, 8'h07};
`ifndef CTR_STEP_CMD_EN
        ops.push_back(8'h06);
        ops.push_back(8'h00);
        ops.push_back(8'h07);
`endif
        foreach (ops[i]) begin
            send_byte(ops[i]);
            apply_op(ops[i]);
            q.push_back(mk(m_run, 0, 0, 1));
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL err op %h got %h exp %h", ops[i], obs(), e);
            end
        end
    endtask

`ifdef CTR_STEP_CMD_EN
    task automatic test_step();
        logic [13:0] e;
        send_byte(8'h06);
        send_byte(8'h03);
        repeat (3) q.push_back(mk(1, 0, 1, 0));
        repeat (2) q.push_back(mk(m_run, 0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL step3[%0d] got %h exp %h", i, obs(), e);
            end
        end
        send_byte(8'h06);
        q.push_back(mk(m_run, 0, 1, 1));
        @(negedge clk);
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL step_arg got %h exp %h", obs(), e);
        end
        send_byte(8'h00);
        repeat (3) q.push_back(mk(m_run, 0, 0, 1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL step0[%0d] got %h exp %h", i, obs(), e);
            end
        end
        send_byte(8'h02);
        m_run = 1'b1;
        send_byte(8'h06);
        send_byte(8'h02);
        repeat (2) q.push_back(mk(1, 0, 1, 0));
        repeat (2) q.push_back(mk(1, 0, 0, 1));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL step_in_run[%0d] got %h exp %h", i, obs(), e);
            end
        end
        send_byte(8'h03);
        m_run = 1'b0;
    endtask
`endif

    task automatic test_back_to_back();
        logic [13:0] e;
        send_byte(8'h01);
        send_byte(8'h77);
        send_byte(8'h02);
        m_lv  = 8'h77;
        m_run = 1'b1;
        q.push_back(mk(1, 0, 0, 1));
        send_byte(8'h03);
        m_run = 1'b0;
        q.push_back(mk(0, 0, 0, 1));
        e = q.pop_front();
        checks++;
        if (e[13:12] !== 2'b10 || e[11:4] !== 8'h77) begin
            errors++;
            $display("FAIL b2b_model got %h required en=1 val=77", e);
        end
        @(negedge clk);
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL b2b got %h exp %h", obs(), e);
        end
    endtask

    task automatic test_reset_abort();
        logic [13:0] e;
        send_byte(8'h01);
        q.push_back(mk(m_run, 0, 1, 1));
        @(negedge clk);
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abort_arg got %h exp %h", obs(), e);
        end
        rst = 1'b1;
        m_run = 0; m_oe = 0; m_err = 0; m_lv = 8'h00;
        q.push_back(mk(0, 0, 0, 0));
        @(negedge clk);
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abort_rst got %h exp %h", obs(), e);
        end
        rst = 1'b0;
        send_byte(8'h55);
        m_err = 1'b1;
        q.push_back(mk(0, 0, 0, 1));
        @(negedge clk);
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL abort_op got %h exp %h", obs(), e);
        end
`ifdef CTR_STEP_CMD_EN
        send_byte(8'h07);
        m_err = 1'b0;
        send_byte(8'h04);
        m_oe = 1'b1;
        send_byte(8'h06);
        send_byte(8'd200);
        repeat (5) q.push_back(mk(1, 0, 1, 0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL burst200[%0d] got %h exp %h", i, obs(), e);
            end
        end
        rst = 1'b1;
        m_run = 0; m_oe = 0; m_err = 0; m_lv = 8'h00;
        q.push_back(mk(0, 0, 0, 0));
        @(negedge clk);
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL burst_rst got %h exp %h", obs(), e);
        end
        rst = 1'b0;
        send_byte(8'h55);
        m_err = 1'b1;
        q.push_back(mk(0, 0, 0, 1));
        @(negedge clk);
        e = q.pop_front();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL burst_op got %h exp %h", obs(), e);
        end
`endif
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        test_reset();
        test_load();
`ifdef CTR_STEP_CMD_EN
        test_step();
`endif
        test_run_oe();
        test_err();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
